pc_fetch_sequencer: RTL and testbench
=====================================

Name: pc_fetch_sequencer

Overview:
Sequences the LEGv8 program counter and instruction fetch. Holds the registered PC and issues req/ack fetches to instruction memory. Presents each fetched word to decode with a valid/ready handshake, then advances the PC by one or redirects it on a taken branch. Sits between the PC incrementer path, instruction memory and the decode stage.

Parameters:
ADDR_W, 8, PC / instruction address width in bits
RESET_VEC, 0, PC value loaded on reset
INSTR_W, 32, instruction word width

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
stall  in  1  pipeline stall; freezes sequencer
branch_taken  in  1  redirect request, one-cycle pulse
branch_target  in  ADDR_W  redirect address, valid with branch_taken
halt  in  1  stop fetching after current instruction
imem_req  out  1  fetch request to instruction memory
imem_addr  out  ADDR_W  fetch address (equals pc)
imem_ack  in  1  memory has returned imem_data this cycle
imem_data  in  INSTR_W  fetched word
instr_valid  out  1  instr holds a valid instruction
instr  out  INSTR_W  registered instruction to decode
instr_ready  in  1  decode accepts instr
pc  out  ADDR_W  current PC, registered
halted  out  1  sequencer in HALT

Behaviour:
- Reset (async, active-high): state=IDLE, pc=RESET_VEC, instr=0, imem_req=0, instr_valid=0, halted=0.
- imem_addr = pc, combinational. imem_req = (state==REQ). instr_valid = (state==HOLD) && !stall. halted = (state==HALT).
- States: IDLE, REQ, HOLD, HALT.
- IDLE: next cycle -> HALT if halt, else -> REQ. Exactly one idle cycle after reset release.
- REQ: imem_req=1 until imem_ack. On imem_ack: instr <= imem_data, -> HOLD. Fetch latency is 1 cycle plus memory wait; no timeout.
- HOLD: handshake completes when instr_ready && !stall. On completion: pc <= pc+1, modulo 2^ADDR_W (all-ones wraps to 0). Then -> HALT if halt, else -> REQ.
- Branch (branch_taken=1, in IDLE/REQ/HOLD): pc <= branch_target, -> REQ.
  - In HOLD: the held instruction is flushed, even if instr_ready=1 the same cycle. Decode must treat that cycle's transfer as squashed. No increment occurs.
  - In REQ with simultaneous imem_ack: data discarded; the new fetch is issued from branch_target on the next cycle.
- Priority: reset > branch_taken > stall > halt > normal flow.
- stall=1 with no branch: state, pc and instr hold; imem_req stays asserted if in REQ. An imem_ack arriving during stall in REQ is still captured, so the memory handshake is never lost. Only the decode handshake is blocked.
- halt is sampled only in IDLE and at HOLD completion. Otherwise it is ignored until the next of those points.
- HALT: imem_req=0, instr_valid=0, pc frozen, branch_taken ignored. Exit only via reset.
- Reset mid-fetch: the outstanding request is abandoned. The memory must tolerate a dropped imem_req.

Optional Feature:
FETCH_COUNT_EN
- Defined: adds output fetch_count [15:0]. It increments on each completed HOLD handshake, saturates at 16'hFFFF, resets to 0, and is unaffected by flushed instructions.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset release, imem_ack one cycle after each req, instr_ready=1 -> fetch addresses 0,1,2,3 on consecutive REQ cycles; instr_valid pulses; pc reaches 4.
- pc=8'hFF, handshake completes -> pc=8'h00, next imem_addr=0.
- In HOLD with instr=0xDEADBEEF, assert branch_taken with target 8'h40 and instr_ready=1 the same cycle -> instr flushed, no increment, next imem_addr=0x40.
- stall=1 for 3 cycles while in HOLD with instr_ready=1 -> instr_valid=0, pc unchanged; on stall release, transfer completes and pc increments once.
- imem_ack delayed 5 cycles -> imem_req held high all 5 cycles, imem_addr stable; instr captured on ack.
- halt=1 during HOLD, then handshake completes -> halted=1, imem_req=0, pc=old+1. A later branch_taken is ignored; reset restores pc=RESET_VEC. With FETCH_COUNT_EN defined, fetch_count equals the number of completed handshakes.

Source files
------------

// File: rtl/pc_fetch_sequencer.sv
// ============================================================================
// Module      : pc_fetch_sequencer
// Description : LEGv8 PC sequencer. It issues req/ack instruction fetches and
//               presents each fetched word to decode over a valid/ready
//               handshake. Define FETCH_COUNT_EN to add the fetch_count output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_fetch_sequencer #(
    parameter int                ADDR_W    = 8,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0,
    parameter int                INSTR_W   = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_target,
    input  logic               halt,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_data,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr,
    input  logic               instr_ready,
    output logic [ADDR_W-1:0]  pc,
    output logic               halted
`ifdef FETCH_COUNT_EN
    ,
    output logic [15:0]        fetch_count
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2,
        S_HALT = 2'd3
    } state_t;

    state_t state;
    logic   xfer_done;

    assign imem_addr   = pc;
    assign imem_req    = (state == S_REQ);
    assign instr_valid = (state == S_HOLD) && !stall;
    assign halted      = (state == S_HALT);

    // A decode transfer only completes when it is not squashed by a redirect.
    assign xfer_done   = (state == S_HOLD) && !branch_taken && instr_ready && !stall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            pc    <= RESET_VEC;
            instr <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (branch_taken) begin
                        pc    <= branch_target;
                        state <= S_REQ;
                    end else if (!stall) begin
                        state <= halt ? S_HALT : S_REQ;
                    end
                end
                S_REQ: begin
                    if (branch_taken) begin
                        pc    <= branch_target;
                        state <= S_REQ;
                    end else if (imem_ack) begin
                        // Captured even under stall so the memory handshake is never lost.
                        instr <= imem_data;
                        state <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (branch_taken) begin
                        pc    <= branch_target;
                        state <= S_REQ;
                    end else if (xfer_done) begin
                        pc    <= pc + ADDR_W'(1);
                        state <= halt ? S_HALT : S_REQ;
                    end
                end
                S_HALT: begin
                    state <= S_HALT;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef FETCH_COUNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_count <= '0;
        end else if (xfer_done && (fetch_count != 16'hFFFF)) begin
            fetch_count <= fetch_count + 16'd1;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_pc_fetch_sequencer.sv
// ============================================================================
// Module      : tb_pc_fetch_sequencer
// Description : Directed, table-driven self-checking bench for pc_fetch_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pc_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        branch_taken;
    logic [7:0]  branch_target;
    logic        halt;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack;
    logic [31:0] imem_data;
    logic        instr_valid;
    logic [31:0] instr;
    logic        instr_ready;
    logic [7:0]  pc;
    logic        halted;
`ifdef FETCH_COUNT_EN
    logic [15:0] fetch_count;
`endif

    int checks = 0;
    int errors = 0;

    pc_fetch_sequencer #(
        .ADDR_W    (8),
        .RESET_VEC (8'h00),
        .INSTR_W   (32)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .halt          (halt),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_data     (imem_data),
        .instr_valid   (instr_valid),
        .instr         (instr),
        .instr_ready   (instr_ready),
        .pc            (pc),
        .halted        (halted)
`ifdef FETCH_COUNT_EN
        ,
        .fetch_count   (fetch_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        br;
        logic [7:0]  tgt;
        logic        halt;
        logic        ack;
        logic [31:0] data;
        logic        ready;
        logic        req;
        logic [7:0]  addr;
        logic        valid;
        logic [31:0] instr;
        logic [7:0]  pc;
        logic        halted;
    } vec_t;

    localparam int NVEC = 27;
    vec_t tbl [NVEC];

    function automatic vec_t mk(input logic s, input logic b, input logic [7:0] t,
                                input logic h, input logic a, input logic [31:0] d,
                                input logic r, input logic e_req, input logic [7:0] e_addr,
                                input logic e_val, input logic [31:0] e_ins,
                                input logic [7:0] e_pc, input logic e_hlt);
        vec_t v;
        v.stall = s;   v.br = b;       v.tgt = t;     v.halt = h;
        v.ack = a;     v.data = d;     v.ready = r;
        v.req = e_req; v.addr = e_addr; v.valid = e_val;
        v.instr = e_ins; v.pc = e_pc;  v.halted = e_hlt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic s, input logic b, input logic [7:0] t, input logic h,
                         input logic a, input logic [31:0] d, input logic r);
        stall = s; branch_taken = b; branch_target = t; halt = h;
        imem_ack = a; imem_data = d; instr_ready = r;
    endtask

    initial begin
        // Cycle-by-cycle: fetch 0..3, flush in HOLD, stall in HOLD,
        // branch with simultaneous ack, 5-cycle memory wait, halt.
        tbl[0]  = mk(0,0,8'h00,0,0,32'h0,0,          0,8'h00,0,32'h0,8'h00,0);
        tbl[1]  = mk(0,0,8'h00,0,1,32'hA000_0000,0,  1,8'h00,0,32'h0,8'h00,0);
        tbl[2]  = mk(0,0,8'h00,0,0,32'h0,1,          0,8'h00,1,32'hA000_0000,8'h00,0);
        tbl[3]  = mk(0,0,8'h00,0,1,32'hA000_0001,0,  1,8'h01,0,32'hA000_0000,8'h01,0);
        tbl[4]  = mk(0,0,8'h00,0,0,32'h0,1,          0,8'h01,1,32'hA000_0001,8'h01,0);
        tbl[5]  = mk(0,0,8'h00,0,1,32'hA000_0002,0,  1,8'h02,0,32'hA000_0001,8'h02,0);
        tbl[6]  = mk(0,0,8'h00,0,0,32'h0,1,          0,8'h02,1,32'hA000_0002,8'h02,0);
        tbl[7]  = mk(0,0,8'h00,0,1,32'hA000_0003,0,  1,8'h03,0,32'hA000_0002,8'h03,0);
        tbl[8]  = mk(0,0,8'h00,0,0,32'h0,1,          0,8'h03,1,32'hA000_0003,8'h03,0);
        tbl[9]  = mk(0,0,8'h00,0,1,32'hDEADBEEF,0,   1,8'h04,0,32'hA000_0003,8'h04,0);
        tbl[10] = mk(0,1,8'h40,0,0,32'h0,1,          0,8'h04,1,32'hDEADBEEF,8'h04,0);
        tbl[11] = mk(0,0,8'h00,0,1,32'h1111_1111,0,  1,8'h40,0,32'hDEADBEEF,8'h40,0);
        tbl[12] = mk(1,0,8'h00,0,0,32'h0,1,          0,8'h40,0,32'h1111_1111,8'h40,0);
        tbl[13] = mk(1,0,8'h00,0,0,32'h0,1,          0,8'h40,0,32'h1111_1111,8'h40,0);
        tbl[14] = mk(1,0,8'h00,0,0,32'h0,1,          0,8'h40,0,32'h1111_1111,8'h40,0);
        tbl[15] = mk(0,0,8'h00,0,0,32'h0,1,          0,8'h40,1,32'h1111_1111,8'h40,0);
        tbl[16] = mk(0,1,8'h80,0,1,32'h3333_3333,0,  1,8'h41,0,32'h1111_1111,8'h41,0);
        for (int i = 17; i <= 21; i++)
            tbl[i] = mk(0,0,8'h00,0,0,32'h0,0,       1,8'h80,0,32'h1111_1111,8'h80,0);
        tbl[22] = mk(0,0,8'h00,0,1,32'h2222_2222,0,  1,8'h80,0,32'h1111_1111,8'h80,0);
        tbl[23] = mk(0,0,8'h00,0,0,32'h0,0,          0,8'h80,1,32'h2222_2222,8'h80,0);
        tbl[24] = mk(0,0,8'h00,1,0,32'h0,1,          0,8'h80,1,32'h2222_2222,8'h80,0);
        tbl[25] = mk(0,1,8'h10,0,0,32'h0,0,          0,8'h81,0,32'h2222_2222,8'h81,1);
        tbl[26] = mk(0,0,8'h00,0,0,32'h0,0,          0,8'h81,0,32'h2222_2222,8'h81,1);

        reset = 1'b1;
        drive(0,0,8'h00,0,0,32'h0,0);
        repeat (2) @(negedge clk);
        chk("reset_req",    {31'b0, imem_req},    32'd0);
        chk("reset_pc",     {24'b0, pc},          32'd0);
        chk("reset_instr",  instr,                32'd0);
        chk("reset_valid",  {31'b0, instr_valid}, 32'd0);
        chk("reset_halted", {31'b0, halted},      32'd0);
        reset = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            drive(tbl[i].stall, tbl[i].br, tbl[i].tgt, tbl[i].halt,
                  tbl[i].ack, tbl[i].data, tbl[i].ready);
            #1;
            chk($sformatf("v%0d_req", i),    {31'b0, imem_req},    {31'b0, tbl[i].req});
            chk($sformatf("v%0d_addr", i),   {24'b0, imem_addr},   {24'b0, tbl[i].addr});
            chk($sformatf("v%0d_valid", i),  {31'b0, instr_valid}, {31'b0, tbl[i].valid});
            chk($sformatf("v%0d_instr", i),  instr,                tbl[i].instr);
            chk($sformatf("v%0d_pc", i),     {24'b0, pc},          {24'b0, tbl[i].pc});
            chk($sformatf("v%0d_halted", i), {31'b0, halted},      {31'b0, tbl[i].halted});
            @(negedge clk);
        end
`ifdef FETCH_COUNT_EN
        chk("fetch_count_table", {16'b0, fetch_count}, 32'd6);
`endif

        // Reset out of HALT, then PC wrap from 8'hFF.
        reset = 1'b1;
        drive(0,0,8'h00,0,0,32'h0,0);
        #1;
        chk("halt_reset_pc",     {24'b0, pc},     32'd0);
        chk("halt_reset_halted", {31'b0, halted}, 32'd0);
`ifdef FETCH_COUNT_EN
        chk("fetch_count_reset", {16'b0, fetch_count}, 32'd0);
`endif
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);                          // IDLE -> REQ
        drive(0,1,8'hFF,0,0,32'h0,0);            // REQ: redirect to FF
        @(negedge clk);
        drive(0,0,8'h00,0,1,32'h55AA_55AA,0);
        #1;
        chk("wrap_addr_ff", {24'b0, imem_addr}, 32'h0000_00FF);
        @(negedge clk);
        drive(0,0,8'h00,0,0,32'h0,1);
        #1;
        chk("wrap_valid", {31'b0, instr_valid}, 32'd1);
        chk("wrap_instr", instr,               32'h55AA_55AA);
        @(negedge clk);
        drive(0,0,8'h00,0,1,32'h6666_6666,0);
        #1;
        chk("wrap_pc",   {24'b0, pc},        32'd0);
        chk("wrap_addr", {24'b0, imem_addr}, 32'd0);
        chk("wrap_req",  {31'b0, imem_req},  32'd1);
        @(negedge clk);
        drive(0,0,8'h00,0,0,32'h0,1);
        @(negedge clk);
        drive(0,0,8'h00,0,0,32'h0,0);
        #1;
        chk("midfetch_pc",  {24'b0, pc},       32'd1);
        chk("midfetch_req", {31'b0, imem_req}, 32'd1);
`ifdef FETCH_COUNT_EN
        chk("fetch_count_wrap", {16'b0, fetch_count}, 32'd2);
`endif
        // Asynchronous reset abandons the outstanding fetch at once.
        reset = 1'b1;
        #1;
        chk("midfetch_reset_req", {31'b0, imem_req}, 32'd0);
        chk("midfetch_reset_pc",  {24'b0, pc},       32'd0);
        @(negedge clk);
        reset = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
